lvds_tx_framer: RTL and testbench

LVDS_TX_FRAMER -- requirements
Module: lvds_tx_framer

---
 rtl/lvds_tx_framer_pkg.sv | 32 +++
 rtl/lvds_tx_framer_if.sv | 22 ++
 rtl/lvds_tx_word_clip.sv | 23 ++
 rtl/lvds_tx_framer.sv | 111 +++++++++++
 tb/tb_lvds_tx_framer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_tx_framer_pkg.sv
// Shared constants, state encoding and marker helper for the LVDS transmit framer.
package lvds_tx_pkg;

  // Line-coding words, all 10 bits wide.
  localparam logic [9:0] TRAIN_WORD = 10'h3A6;
  localparam logic [9:0] SYNC0      = 10'h3FF;
  localparam logic [9:0] SYNC1      = 10'h000;
  localparam logic [9:0] CODE_SOF   = 10'h2AC;
  localparam logic [9:0] CODE_SOL   = 10'h200;
  localparam logic [9:0] CODE_EOL   = 10'h274;
  localparam logic [9:0] CODE_EOF   = 10'h2D8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_POST = 2'd3
  } state_e;

  // Preamble/trailer word for marker slot idx: SYNC0, SYNC1, SYNC1, then the line code.
  function automatic logic [9:0] marker_word(input logic [1:0] idx, input logic [9:0] code);
    logic [9:0] w;
    case (idx)
      2'd0:    w = SYNC0;
      2'd1:    w = SYNC1;
      2'd2:    w = SYNC1;
      default: w = code;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lvds_tx_framer_if.sv
// Pixel-beat stream between an upstream source and the LVDS transmit framer.
interface lvds_tx_framer_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 10
);
  logic [LANES*DATA_W-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sof;
  logic                    s_eol;
  logic                    s_eof;

  modport master (
    output s_data, s_valid, s_sof, s_eol, s_eof,
    input  s_ready
  );

  modport slave (
    input  s_data, s_valid, s_sof, s_eol, s_eof,
    output s_ready
  );
endinterface

// File: rtl/lvds_tx_word_clip.sv
// Keeps a payload word from aliasing the all-ones/all-zeros sync words.
module lvds_tx_word_clip #(
  parameter int DATA_W  = 10,
  parameter int CLIP_EN = 1
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Nudge all-ones down by one and all-zeros up by one; everything else passes.
  always_comb begin
    // NOTE: dout gets a default before any branch so no path leaves it unassigned (no latch).
    dout = din;
    if (CLIP_EN != 0) begin
      if (din == '1) begin
        dout = {{(DATA_W-1){1'b1}}, 1'b0};
      end else if (din == '0) begin
        dout = DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/lvds_tx_framer.sv
// Frames pixel beats into per-lane serializer words: training in idle, a
// sync preamble and line code before each line, a trailer after it.
module lvds_tx_framer
  import lvds_tx_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int DATA_W  = 10,
  parameter int CLIP_EN = 1
) (
  input  logic                    gclk,
  input  logic                    rst_n,
  input  logic                    en,
  lvds_tx_framer_if.slave         s,
  output logic [LANES*DATA_W-1:0] tx_data,
  output logic                    busy,
  output logic                    underrun,
  output logic [15:0]             line_cnt
);

  state_e                  state;
  logic [1:0]              cnt;      // marker slot, shared by PRE and POST
  logic                    sof_l;
  logic                    eof_l;
  logic [LANES*DATA_W-1:0] clipped;

  // Same word on every lane.
  function automatic logic [LANES*DATA_W-1:0] fill(input logic [9:0] w);
    return {LANES{DATA_W'(w)}};
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lvds_tx_word_clip #(
      .DATA_W  (DATA_W),
      .CLIP_EN (CLIP_EN)
    ) u_clip (
      .din  (s.s_data[i*DATA_W +: DATA_W]),
      .dout (clipped[i*DATA_W +: DATA_W])
    );
  end

  // Ready and busy come straight from the state register, never from s_valid.
  assign s.s_ready = (state == ST_DATA);
  assign busy      = (state != ST_IDLE);

  // Line framing FSM; tx_data is the word for the current state, seen one cycle later.
  always_ff @(posedge gclk) begin
    // NOTE: reset is synchronous (sampled only on gclk), and all state uses <= so
    // every register sees the pre-edge values of the others.
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      sof_l    <= 1'b0;
      eof_l    <= 1'b0;
      tx_data  <= fill(TRAIN_WORD);
      underrun <= 1'b0;
      line_cnt <= 16'd0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_data <= fill(TRAIN_WORD);
          if (en && s.s_valid) begin
            state <= ST_PRE;
            cnt   <= 2'd0;
            sof_l <= s.s_sof;
            if (s.s_sof) begin
              line_cnt <= 16'd0;
            end
          end
        end

        ST_PRE: begin
          tx_data <= fill(marker_word(cnt, sof_l ? CODE_SOF : CODE_SOL));
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (s.s_valid) begin
            tx_data <= clipped;
            if (s.s_eol) begin
              state <= ST_POST;
              cnt   <= 2'd0;
              eof_l <= s.s_eof;
            end
          end else begin
            // Gap inside a line: pad with training and flag it, keep waiting.
            tx_data  <= fill(TRAIN_WORD);
            underrun <= 1'b1;
          end
        end

        ST_POST: begin
          tx_data <= fill(marker_word(cnt, eof_l ? CODE_EOF : CODE_EOL));
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state    <= ST_IDLE;
            line_cnt <= line_cnt + 16'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench: two framers (clipping on and off) driven in lockstep.
module tb_lvds_tx_framer;

  localparam int LANES  = 4;
  localparam int DATA_W = 10;
  localparam int W      = LANES * DATA_W;

  logic         gclk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] tx0, tx1;
  logic         busy0, busy1;
  logic         und0, und1;
  logic [15:0]  lc0, lc1;

  int total = 0;
  int bad   = 0;

  lvds_tx_framer_if #(.LANES(LANES), .DATA_W(DATA_W)) bus0 ();
  lvds_tx_framer_if #(.LANES(LANES), .DATA_W(DATA_W)) bus1 ();

  lvds_tx_framer #(.LANES(LANES), .DATA_W(DATA_W), .CLIP_EN(1)) dut (
    .gclk     (gclk),
    .rst_n    (rst_n),
    .en       (en),
    .s        (bus0),
    .tx_data  (tx0),
    .busy     (busy0),
    .underrun (und0),
    .line_cnt (lc0)
  );

  lvds_tx_framer #(.LANES(LANES), .DATA_W(DATA_W), .CLIP_EN(0)) dut_noclip (
    .gclk     (gclk),
    .rst_n    (rst_n),
    .en       (en),
    .s        (bus1),
    .tx_data  (tx1),
    .busy     (busy1),
    .underrun (und1),
    .line_cnt (lc1)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  function automatic logic [W-1:0] rep(input logic [9:0] w);
    return {LANES{w}};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic sof, input logic eol, input logic eof);
    bus0.s_valid = v;  bus1.s_valid = v;
    bus0.s_data  = d;  bus1.s_data  = d;
    bus0.s_sof   = sof; bus1.s_sof  = sof;
    bus0.s_eol   = eol; bus1.s_eol  = eol;
    bus0.s_eof   = eof; bus1.s_eof  = eof;
  endtask

  task automatic chk_tx(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1);
    check({tag, "/clip"},   tx0, e0);
    check({tag, "/noclip"}, tx1, e1);
  endtask

  // Single-beat line from IDLE through POST.
  task automatic one_line(input string tag, input logic sof, input logic [W-1:0] d,
                          input logic eof, input logic [9:0] pre_code,
                          input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [9:0] post_code, input logic [15:0] lc_exp);
    drive(1'b1, d, sof, 1'b1, eof);
    tick(); chk_tx({tag, "_idle"}, rep(10'h3A6), rep(10'h3A6));
    tick(); chk_tx({tag, "_pre0"}, rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx({tag, "_pre1"}, rep(10'h000), rep(10'h000));
    tick(); chk_tx({tag, "_pre2"}, rep(10'h000), rep(10'h000));
    tick(); chk_tx({tag, "_pre3"}, rep(pre_code), rep(pre_code));
    drive(1'b1, d, 1'b0, 1'b1, eof);
    tick(); chk_tx({tag, "_data"}, e0, e1);
    drive(1'b0, rep(10'h000), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx({tag, "_post0"}, rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx({tag, "_post1"}, rep(10'h000), rep(10'h000));
    tick(); chk_tx({tag, "_post2"}, rep(10'h000), rep(10'h000));
    tick(); chk_tx({tag, "_post3"}, rep(post_code), rep(post_code));
    check({tag, "_lcnt"}, W'(lc0), W'(lc_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst_n = 1'b0;
    en    = 1'b0;
    drive(1'b0, rep(10'h000), 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_tx("rst_tx", rep(10'h3A6), rep(10'h3A6));
    check("rst_busy",  W'(busy0), W'(1'b0));
    check("rst_und",   W'(und0), W'(1'b0));
    check("rst_lcnt",  W'(lc0), W'(16'd0));
    check("rst_ready", W'(bus0.s_ready), W'(1'b0));
    rst_n = 1'b1;

    // Idle training with en but no data.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_tx", tx0, rep(10'h3A6));
      check("idle_busy", W'(busy0), W'(1'b0));
    end

    // Single-line frame: 123, 045, 3FF(eol+eof).
    drive(1'b1, rep(10'h123), 1'b1, 1'b0, 1'b0);
    tick(); chk_tx("s_idle", rep(10'h3A6), rep(10'h3A6));
    check("s_busy", W'(busy0), W'(1'b1));
    tick(); chk_tx("s_pre0", rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx("s_pre1", rep(10'h000), rep(10'h000));
    tick(); chk_tx("s_pre2", rep(10'h000), rep(10'h000));
    tick(); chk_tx("s_pre3", rep(10'h2AC), rep(10'h2AC));
    check("s_ready", W'(bus0.s_ready), W'(1'b1));
    tick(); chk_tx("s_d0", rep(10'h123), rep(10'h123));
    drive(1'b1, rep(10'h045), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("s_d1", rep(10'h045), rep(10'h045));
    drive(1'b1, rep(10'h3FF), 1'b0, 1'b1, 1'b1);
    tick(); chk_tx("s_d2", rep(10'h3FE), rep(10'h3FF));
    drive(1'b0, rep(10'h000), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("s_post0", rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx("s_post1", rep(10'h000), rep(10'h000));
    tick(); chk_tx("s_post2", rep(10'h000), rep(10'h000));
    check("s_lcnt0", W'(lc0), W'(16'd0));
    tick(); chk_tx("s_post3", rep(10'h2D8), rep(10'h2D8));
    check("s_lcnt1", W'(lc0), W'(16'd1));
    tick(); chk_tx("s_train", rep(10'h3A6), rep(10'h3A6));
    check("s_busy_end", W'(busy0), W'(1'b0));

    // Mid-line gap of two cycles; stray eof without eol is ignored.
    drive(1'b1, rep(10'h111), 1'b0, 1'b0, 1'b1);
    tick(); chk_tx("g_idle", rep(10'h3A6), rep(10'h3A6));
    tick(); chk_tx("g_pre0", rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx("g_pre1", rep(10'h000), rep(10'h000));
    tick(); chk_tx("g_pre2", rep(10'h000), rep(10'h000));
    tick(); chk_tx("g_pre3", rep(10'h200), rep(10'h200));
    tick(); chk_tx("g_d0", rep(10'h111), rep(10'h111));
    check("g_und0", W'(und0), W'(1'b0));
    drive(1'b0, rep(10'h155), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("g_gap0", rep(10'h3A6), rep(10'h3A6));
    check("g_und1", W'(und0), W'(1'b1));
    tick(); chk_tx("g_gap1", rep(10'h3A6), rep(10'h3A6));
    check("g_und2", W'(und0), W'(1'b1));
    check("g_busy", W'(busy0), W'(1'b1));
    drive(1'b1, rep(10'h222), 1'b0, 1'b1, 1'b0);
    tick(); chk_tx("g_d1", rep(10'h222), rep(10'h222));
    check("g_und3", W'(und0), W'(1'b0));
    drive(1'b0, rep(10'h000), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("g_post0", rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx("g_post1", rep(10'h000), rep(10'h000));
    tick(); chk_tx("g_post2", rep(10'h000), rep(10'h000));
    tick(); chk_tx("g_post3", rep(10'h274), rep(10'h274));
    check("g_lcnt", W'(lc0), W'(16'd2));

    // Three-line frame; first beat has per-lane distinct words.
    one_line("m1", 1'b1, {10'h2AA, 10'h155, 10'h000, 10'h3FF}, 1'b0, 10'h2AC,
             {10'h2AA, 10'h155, 10'h001, 10'h3FE}, {10'h2AA, 10'h155, 10'h000, 10'h3FF},
             10'h274, 16'd1);
    one_line("m2", 1'b0, rep(10'h000), 1'b0, 10'h200,
             rep(10'h001), rep(10'h000), 10'h274, 16'd2);
    one_line("m3", 1'b0, rep(10'h3FF), 1'b1, 10'h200,
             rep(10'h3FE), rep(10'h3FF), 10'h2D8, 16'd3);

    // en dropped on the second beat of a four-beat line.
    drive(1'b1, rep(10'h101), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("e_idle", rep(10'h3A6), rep(10'h3A6));
    tick(); tick(); tick();
    tick(); chk_tx("e_pre3", rep(10'h200), rep(10'h200));
    tick(); chk_tx("e_d0", rep(10'h101), rep(10'h101));
    drive(1'b1, rep(10'h102), 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    tick(); chk_tx("e_d1", rep(10'h102), rep(10'h102));
    drive(1'b1, rep(10'h103), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("e_d2", rep(10'h103), rep(10'h103));
    drive(1'b1, rep(10'h104), 1'b0, 1'b1, 1'b0);
    tick(); chk_tx("e_d3", rep(10'h104), rep(10'h104));
    drive(1'b1, rep(10'h105), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("e_post0", rep(10'h3FF), rep(10'h3FF));
    tick(); tick();
    tick(); chk_tx("e_post3", rep(10'h274), rep(10'h274));
    check("e_lcnt", W'(lc0), W'(16'd4));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_tx("e_hold", rep(10'h3A6), rep(10'h3A6));
      check("e_hold_busy", W'(busy0), W'(1'b0));
      check("e_hold_ready", W'(bus0.s_ready), W'(1'b0));
    end

    // Reset pulsed during PRE word 2.
    en = 1'b1;
    drive(1'b1, rep(10'h1AB), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("r_idle", rep(10'h3A6), rep(10'h3A6));
    tick(); chk_tx("r_pre0", rep(10'h3FF), rep(10'h3FF));
    tick(); chk_tx("r_pre1", rep(10'h000), rep(10'h000));
    rst_n = 1'b0;
    tick(); chk_tx("r_tx", rep(10'h3A6), rep(10'h3A6));
    check("r_busy", W'(busy0), W'(1'b0));
    check("r_lcnt", W'(lc0), W'(16'd0));
    check("r_ready", W'(bus0.s_ready), W'(1'b0));
    rst_n = 1'b1;
    drive(1'b0, rep(10'h000), 1'b0, 1'b0, 1'b0);
    tick(); chk_tx("r_after", rep(10'h3A6), rep(10'h3A6));
    check("r_after_busy", W'(busy0), W'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
